// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between a fixed-priority
// video read port (m0) and a CPU read/write port (m1), with a starvation guard
// that forces a CPU slot after MAX_RUN back-to-back video grants.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   m0_req/m0_addr                    video read request and address
//   m0_gnt/m0_rvalid/m0_rdata         video grant and read return
//   m1_req/m1_rw/m1_addr/m1_wdata     CPU request (rw: 1 = read, 0 = write)
//   m1_gnt/m1_rvalid/m1_rdata         CPU grant and read return
//   ram_cs/ram_rw/ram_addr/ram_wdata  RAM control, driven by the granted port
//   ram_rdata                         RAM read data, valid the cycle after a read
module ram_arbiter #(
    parameter int A       = 12,
    parameter int D       = 8,
    parameter int MAX_RUN = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         m0_req,
    input  logic [A-1:0] m0_addr,
    output logic         m0_gnt,
    output logic         m0_rvalid,
    output logic [D-1:0] m0_rdata,
    input  logic         m1_req,
    input  logic         m1_rw,
    input  logic [A-1:0] m1_addr,
    input  logic [D-1:0] m1_wdata,
    output logic         m1_gnt,
    output logic         m1_rvalid,
    output logic [D-1:0] m1_rdata,
    output logic         ram_cs,
    output logic         ram_rw,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);
    typedef enum logic {NORMAL, FORCED} state_t;
    state_t       state, state_nx;
    logic [3:0]   run, run_nx;
    logic         own0, own1;
    logic [D-1:0] hold0, hold1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= NORMAL;
            run   <= '0;
            own0  <= 1'b0;
            own1  <= 1'b0;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
            own0  <= m0_gnt;
            own1  <= m1_gnt & m1_rw;
            if (own0) hold0 <= ram_rdata;
            if (own1) hold1 <= ram_rdata;
        end
    end

    // An m0 grant can only reach the increment branch while m1 is waiting in
    // NORMAL below the limit, so the counter saturates by forcing instead.
    always_comb begin
        state_nx = state;
        run_nx   = run;
        if (state == NORMAL && m0_gnt && m1_req && run == 4'(MAX_RUN - 1)) begin
            state_nx = FORCED;
            run_nx   = '0;
        end else if (m1_gnt || !m1_req) begin
            state_nx = NORMAL;
            run_nx   = '0;
        end else if (m0_gnt) begin
            run_nx = run + 4'd1;
        end
    end

    always_comb begin
        m1_gnt    = reset_n & m1_req & (state == FORCED | ~m0_req);
        m0_gnt    = reset_n & m0_req & ~m1_gnt;
        ram_cs    = m0_gnt | m1_gnt;
        ram_rw    = m1_gnt ? m1_rw : 1'b1;
        ram_addr  = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
        ram_wdata = m1_gnt ? m1_wdata : '0;
        // Gating with reset_n drops a return whose grant preceded reset.
        m0_rvalid = reset_n & own0;
        m1_rvalid = reset_n & own1;
        m0_rdata  = own0 ? ram_rdata : hold0;
        m1_rdata  = own1 ? ram_rdata : hold1;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter with a RAM model.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m1_rw = 1'b1;
    logic [11:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]  m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        ram_cs, ram_rw;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  mem [0:4095];

    typedef struct {int port; logic [7:0] data; int due;} exp_t;
    exp_t sb[$];
    int compared = 0, failed = 0, cyc_n = 0;

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    always @(posedge clk)
        if (ram_cs) begin
            if (ram_rw) ram_rdata <= mem[ram_addr];
            else mem[ram_addr] <= ram_wdata;
        end

    task automatic chk(input int port, input logic [7:0] data);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            failed++;
            $display("FAIL rvalid_unexpected cycle %0d: port %0d data %h, none required", cyc_n, port, data);
        end else begin
            e = sb.pop_front();
            if (e.port != port || e.data !== data || e.due != cyc_n) begin
                failed++;
                $display("FAIL rvalid cycle %0d: got port %0d data %h, want port %0d data %h at cycle %0d",
                         cyc_n, port, data, e.port, e.data, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        if (m0_rvalid) chk(0, m0_rdata);
        if (m1_rvalid) chk(1, m1_rdata);
        if (sb.size() > 0 && sb[0].due < cyc_n) begin
            compared++;
            failed++;
            $display("FAIL rvalid_missing cycle %0d: got no rvalid, want port %0d data %h at cycle %0d",
                     cyc_n, sb[0].port, sb[0].data, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic drive(input logic r0, input logic [11:0] a0, input logic r1, input logic rw,
                         input logic [11:0] a1, input logic [7:0] wd, input logic eg0,
                         input logic eg1, input logic ret, input logic [7:0] ed);
        logic [11:0] ea;
        logic        erw;
        m0_req = r0; m0_addr = a0; m1_req = r1; m1_rw = rw; m1_addr = a1; m1_wdata = wd;
        ea  = eg0 ? a0 : eg1 ? a1 : 12'h000;
        erw = eg1 ? rw : 1'b1;
        #3;
        compared++;
        if (m0_gnt !== eg0 || m1_gnt !== eg1 || ram_cs !== (eg0 | eg1) || ram_addr !== ea || ram_rw !== erw) begin
            failed++;
            $display("FAIL grant cycle %0d: got g0=%b g1=%b cs=%b addr=%h rw=%b, want g0=%b g1=%b cs=%b addr=%h rw=%b",
                     cyc_n, m0_gnt, m1_gnt, ram_cs, ram_addr, ram_rw, eg0, eg1, eg0 | eg1, ea, erw);
        end
        if (ret) sb.push_back('{eg0 ? 0 : 1, ed, cyc_n + 1});
        @(posedge clk); #1;
    endtask

    task automatic rst_check(input int n);
        reset_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m1_rw = 1'b1;
        for (int i = 0; i < n; i++) begin
            #3;
            compared++;
            if (m0_gnt || m1_gnt || ram_cs || m0_rvalid || m1_rvalid) begin
                failed++;
                $display("FAIL reset cycle %0d: got g0=%b g1=%b cs=%b rv0=%b rv1=%b, want all 0",
                         cyc_n, m0_gnt, m1_gnt, ram_cs, m0_rvalid, m1_rvalid);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
    endtask

    task automatic contend(input int n);
        int j = 0;
        for (int i = 0; i < n; i++) begin
            logic g1;
            g1 = (i % 5 == 4);
            drive(1'b1, 12'(12'h300 + j), 1'b1, 1'b1, 12'h010, 8'h00, !g1, g1, 1'b1,
                  g1 ? 8'hA5 : 8'(8'h40 + j));
            if (!g1) j++;
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[12'h300 + k] = 8'(8'h40 + k);
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h200] = 8'h33; mem[12'h010] = 8'h00;
        @(posedge clk); #1;
        rst_check(2);
        drive(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5);
        drive(1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        contend(10);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 12'(12'h300 + i % 16), 1'b0, 1'b1, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h40 + i % 16));
        for (int i = 0; i < 4; i++)
            drive(1'b1, 12'(12'h300 + i), 1'b1, 1'b1, 12'h010, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h40 + i));
        drive(1'b1, 12'h304, 1'b0, 1'b1, 12'h010, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44);
        contend(5);
        drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        rst_check(2);
        contend(5);
        drive(1'b1, 12'h100, 1'b0, 1'b1, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11);
        drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h200, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33);
        drive(1'b1, 12'h101, 1'b0, 1'b1, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22);
        drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h200, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33);
        drive(1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        compared++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL leftover: %0d returns outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
